seq_decoder_nx: RTL and testbench

Parametrised binary-to-one-hot decoder with a registered output stage and valid/ready handshakes on both sides. It generalises the fixed 3-to-8 decoder to SEL_W select bits and optional active-low outputs. A second mode runs a built-in scan sequencer that walks the one-hot output across all lines, used for output-line and LED/strobe bring-up. It sits between a select-producing controller and downstream strobe/enable consumers.

---
 rtl/seq_dec_pkg.sv | 21 ++
 rtl/seq_decoder_nx_dec_onehot.sv | 20 ++
 rtl/seq_decoder_nx.sv | 139 +++++++++++++
 tb/tb_seq_decoder_nx.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/seq_dec_pkg.sv
// Shared types and helpers for the one-hot sequencing decoder.
// Helpers work on a MAX_OUT-wide vector; callers slice down to their line count.
package seq_dec_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SCAN} state_t;

  localparam int MAX_OUT = 256;

  function automatic logic [MAX_OUT-1:0] onehot(input int unsigned idx, input int unsigned width);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (idx < width && idx < MAX_OUT) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_OUT-1:0] apply_pol(input logic [MAX_OUT-1:0] pattern,
                                                   input logic act_low);
    return act_low ? ~pattern : pattern;
  endfunction

endpackage

// File: rtl/seq_decoder_nx_dec_onehot.sv
// Combinational SEL_W -> 2**SEL_W one-hot decoder; en=0 yields no active line.
module dec_onehot
  import seq_dec_pkg::*;
#(
  parameter  int SEL_W = 3,
  localparam int OUT_N = 2**SEL_W
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [OUT_N-1:0] lines
);

  logic [MAX_OUT-1:0] full;

  always_comb begin
    full  = onehot(32'(sel), OUT_N);
    lines = en ? full[OUT_N-1:0] : '0;
  end

endmodule

// File: rtl/seq_decoder_nx.sv
// Registered one-hot decoder with valid/ready on both sides and a scan mode
// that walks the active line across all outputs, DWELL accepted beats per line.
module seq_decoder_nx
  import seq_dec_pkg::*;
#(
  parameter  int SEL_W   = 3,
  parameter  bit ACT_LOW = 1'b0,
  parameter  int DWELL   = 4,
  localparam int OUT_N   = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_N-1:0] dout,
  output logic [SEL_W-1:0] idx,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int DW_W = $clog2(DWELL+1);
  localparam logic [OUT_N-1:0] IDLE_PAT = {OUT_N{ACT_LOW}};
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL-1);

  state_t             state;
  logic [DW_W-1:0]    dwell;
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;
  logic [OUT_N-1:0]   raw;
  logic [MAX_OUT-1:0] pol_full;
  logic [OUT_N-1:0]   active;
  logic               accept;

  // One decoder serves both paths: scan feeds the next index, scan entry feeds 0.
  always_comb begin
    dec_sel = sel;
    dec_en  = en;
    if (state == S_SCAN) begin
      dec_sel = idx + SEL_W'(1);
      dec_en  = 1'b1;
    end else if (state == S_IDLE && mode) begin
      dec_sel = '0;
      dec_en  = 1'b1;
    end
  end

  dec_onehot #(.SEL_W(SEL_W)) u_dec (
    .sel   (dec_sel),
    .en    (dec_en),
    .lines (raw)
  );

  always_comb begin
    pol_full = apply_pol(MAX_OUT'(raw), ACT_LOW);
    active   = pol_full[OUT_N-1:0];
  end

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE:  in_ready = 1'b1;
        S_HOLD:  in_ready = out_ready && !mode;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready && !mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dout      <= IDLE_PAT;
      idx       <= '0;
      out_valid <= 1'b0;
      dwell     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mode) begin
            state     <= S_SCAN;
            dout      <= active;
            idx       <= '0;
            out_valid <= 1'b1;
            dwell     <= '0;
          end else if (accept) begin
            state     <= S_HOLD;
            dout      <= active;
            idx       <= en ? sel : '0;
            out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            if (accept) begin
              dout <= active;
              idx  <= en ? sel : '0;
            end else begin
              state     <= S_IDLE;
              dout      <= IDLE_PAT;
              idx       <= '0;
              out_valid <= 1'b0;
            end
          end
        end
        S_SCAN: begin
          // Leaving scan wins over a dwell advance in the same beat.
          if (out_ready) begin
            if (!mode) begin
              state     <= S_IDLE;
              dout      <= IDLE_PAT;
              idx       <= '0;
              out_valid <= 1'b0;
              dwell     <= '0;
            end else if (dwell == DW_LAST) begin
              dwell <= '0;
              idx   <= idx + SEL_W'(1);
              dout  <= active;
            end else begin
              dwell <= dwell + DW_W'(1);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          dout      <= IDLE_PAT;
          idx       <= '0;
          out_valid <= 1'b0;
          dwell     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder_nx.sv
// Directed bench: instance a is SEL_W=3 active-high DWELL=2, instance b is
// SEL_W=4 active-low DWELL=4; expected values are hand-computed constants.
module tb_seq_decoder_nx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_mode, a_en, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0] a_sel, a_idx;
  logic [7:0] a_dout;

  logic        b_rst, b_mode, b_en, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [3:0]  b_sel, b_idx;
  logic [15:0] b_dout;

  int n_chk  = 0;
  int n_fail = 0;

  seq_decoder_nx #(.SEL_W(3), .ACT_LOW(1'b0), .DWELL(2)) u_a (
    .clk(clk), .rst(a_rst), .mode(a_mode), .en(a_en), .sel(a_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .dout(a_dout), .idx(a_idx),
    .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  seq_decoder_nx #(.SEL_W(4), .ACT_LOW(1'b1), .DWELL(4)) u_b (
    .clk(clk), .rst(b_rst), .mode(b_mode), .en(b_en), .sel(b_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .dout(b_dout), .idx(b_idx),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; a_mode = 1'b0; a_en = 1'b0; a_sel = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_rst = 1'b1; b_mode = 1'b0; b_en = 1'b0; b_sel = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;

    // 1. reset
    tick();
    tick();
    chk("rst_dout", 32'(a_dout), 32'h00);
    chk("rst_ov", 32'(a_out_valid), 0);
    chk("rst_inrdy", 32'(a_in_ready), 0);
    a_rst = 1'b0;
    tick();
    chk("rel_inrdy", 32'(a_in_ready), 1);
    chk("rel_ov", 32'(a_out_valid), 0);

    // 2. direct sweep, one beat per cycle
    a_en = 1'b1; a_out_ready = 1'b1; a_in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_sel = 3'(i);
      #1;
      chk($sformatf("sweep_inrdy%0d", i), 32'(a_in_ready), 1);
      tick();
      chk($sformatf("sweep_dout%0d", i), 32'(a_dout), 32'(8'h01 << i));
      chk($sformatf("sweep_idx%0d", i), 32'(a_idx), 32'(i));
      chk($sformatf("sweep_ov%0d", i), 32'(a_out_valid), 1);
    end
    a_in_valid = 1'b0;
    tick();
    chk("sweep_end_ov", 32'(a_out_valid), 0);
    chk("sweep_end_dout", 32'(a_dout), 32'h00);

    // 3. enable off, then backpressure
    a_sel = 3'd5; a_en = 1'b0; a_in_valid = 1'b1;
    tick();
    chk("en0_dout", 32'(a_dout), 32'h00);
    chk("en0_idx", 32'(a_idx), 0);
    chk("en0_ov", 32'(a_out_valid), 1);
    a_sel = 3'd3; a_en = 1'b1;
    tick();
    chk("bp_load", 32'(a_dout), 32'h08);
    a_out_ready = 1'b0; a_sel = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d", i), 32'(a_dout), 32'h08);
      chk($sformatf("bp_inrdy%0d", i), 32'(a_in_ready), 0);
      chk($sformatf("bp_idx%0d", i), 32'(a_idx), 3);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_inrdy", 32'(a_in_ready), 1);
    tick();
    chk("bp_accept", 32'(a_dout), 32'h40);
    chk("bp_accept_idx", 32'(a_idx), 6);
    a_in_valid = 1'b0;
    tick();
    chk("bp_idle", 32'(a_out_valid), 0);

    // 4. scan with wrap, DWELL=2
    a_mode = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tick();
      chk($sformatf("scan_dout%0d", k), 32'(a_dout), 32'(8'h01 << ((k / 2) % 8)));
      chk($sformatf("scan_idx%0d", k), 32'(a_idx), 32'((k / 2) % 8));
      chk($sformatf("scan_ov%0d", k), 32'(a_out_valid), 1);
    end
    tick();
    chk("scan_l1", 32'(a_dout), 32'h02);
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("scan_freeze%0d", i), 32'(a_dout), 32'h02);
      chk($sformatf("scan_inrdy%0d", i), 32'(a_in_ready), 0);
    end
    a_out_ready = 1'b1;
    tick();
    chk("scan_dwell_kept", 32'(a_dout), 32'h02);
    tick();
    chk("scan_adv", 32'(a_dout), 32'h04);
    a_mode = 1'b0;
    tick();
    chk("scan_exit_ov", 32'(a_out_valid), 0);
    chk("scan_exit_dout", 32'(a_dout), 32'h00);
    chk("scan_exit_idx", 32'(a_idx), 0);

    // 5. mode change while a beat is held
    a_sel = 3'd4; a_en = 1'b1; a_in_valid = 1'b1;
    tick();
    chk("mc_load", 32'(a_dout), 32'h10);
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mc_hold%0d", i), 32'(a_dout), 32'h10);
      chk($sformatf("mc_ov%0d", i), 32'(a_out_valid), 1);
    end
    a_out_ready = 1'b1;
    tick();
    chk("mc_gap_ov", 32'(a_out_valid), 0);
    chk("mc_gap_dout", 32'(a_dout), 32'h00);
    tick();
    chk("mc_scan0", 32'(a_dout), 32'h01);
    chk("mc_scan0_ov", 32'(a_out_valid), 1);
    a_mode = 1'b0;
    tick();
    chk("mc_exit_ov", 32'(a_out_valid), 0);
    chk("mc_exit_dout", 32'(a_dout), 32'h00);

    // 6. active-low, SEL_W=4
    chk("b_rst_dout", 32'(b_dout), 32'hFFFF);
    chk("b_rst_ov", 32'(b_out_valid), 0);
    b_rst = 1'b0; b_sel = 4'd9; b_en = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    chk("b_dir_dout", 32'(b_dout), 32'hFDFF);
    chk("b_dir_idx", 32'(b_idx), 9);
    b_in_valid = 1'b0;
    tick();
    chk("b_idle_dout", 32'(b_dout), 32'hFFFF);
    chk("b_idle_ov", 32'(b_out_valid), 0);
    b_mode = 1'b1;
    tick();
    chk("b_scan0", 32'(b_dout), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("b_dwell%0d", i), 32'(b_dout), 32'hFFFE);
    end
    tick();
    chk("b_scan1", 32'(b_dout), 32'hFFFD);
    chk("b_scan1_idx", 32'(b_idx), 1);
    b_rst = 1'b1;
    tick();
    chk("b_midrst_dout", 32'(b_dout), 32'hFFFF);
    chk("b_midrst_ov", 32'(b_out_valid), 0);
    chk("b_midrst_idx", 32'(b_idx), 0);
    chk("b_midrst_inrdy", 32'(b_in_ready), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
